biu_clk_en_div: RTL and testbench

//  Consumes the 3-bit clock-ratio value from the APB clock-ratio register (pad_biu_clkratio) and

---
 rtl/biu_clk_en_div_pkg.sv | 11 +
 rtl/biu_clk_en_div.sv | 87 ++++++++
 tb/tb_biu_clk_en_div.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biu_clk_en_div_pkg.sv
// Shared clock-ratio definitions used by the APB ratio register, the BIU and
// the clock-enable divider. The divide factor for a ratio value r is N = r + 1.
package biu_clk_en_div_pkg;

    // Width of the clock-ratio field carried on pad_biu_clkratio
    localparam int CLK_RATIO_W = 3;

    // Ratio in effect out of reset: N = 1, enable every cycle
    localparam int CLK_RATIO_RESET = 0;

endpackage

// File: rtl/biu_clk_en_div.sv
// Bus clock-enable divider. Produces a single-cycle clk_en once every
// (cur_ratio + 1) cycles, plus a one-cycle-early strobe. New ratios are
// adopted only on a period boundary or while idle, so enable periods are
// never shortened or stretched.
module biu_clk_en_div
    import biu_clk_en_div_pkg::*;
#(
    parameter int                 RATIO_W     = CLK_RATIO_W,
    parameter logic [RATIO_W-1:0] RESET_RATIO = RATIO_W'(CLK_RATIO_RESET)
) (
    input  logic               i_pad_clk,
    input  logic               clkrst,
    input  logic               div_en,
    input  logic [RATIO_W-1:0] pad_biu_clkratio,
    output logic               clk_en,
    output logic               clk_en_pre,
    output logic [RATIO_W-1:0] cur_ratio,
    output logic [RATIO_W-1:0] period_cnt,
    output logic               ratio_chg_done
);

    logic               run_reg;
    logic               run_next;
    logic [RATIO_W-1:0] cnt_reg;
    logic [RATIO_W-1:0] cnt_next;
    logic [RATIO_W-1:0] ratio_reg;
    logic [RATIO_W-1:0] ratio_next;
    logic [RATIO_W-1:0] req_q_reg;
    logic               done_reg;
    logic               done_next;

    logic               boundary;
    logic               pending;
    logic               adopt;

    // Period boundary, pending-change and adoption decode
    always_comb begin
        boundary = run_reg && (cnt_reg == ratio_reg);
        pending  = (req_q_reg != ratio_reg);
        // A ratio can switch safely at the end of a period or whenever idle
        adopt    = pending && (boundary || !run_reg);
    end

    // Next-state computation for the counter, ratio, run flag and done pulse
    always_comb begin
        run_next   = div_en;
        ratio_next = ratio_reg;
        cnt_next   = '0;
        done_next  = adopt;
        if (adopt) begin
            ratio_next = req_q_reg;
        end
        // Count only while running and staying enabled; a falling div_en
        // discards the remainder of the period so the counter restarts at 0.
        if (run_reg && div_en && !boundary && !adopt) begin
            cnt_next = cnt_reg + RATIO_W'(1);
        end
    end

    // State registers; reset overrides every other update
    always_ff @(posedge i_pad_clk) begin
        if (clkrst) begin
            run_reg   <= 1'b0;
            cnt_reg   <= '0;
            ratio_reg <= RESET_RATIO;
            req_q_reg <= RESET_RATIO;
            done_reg  <= 1'b0;
        end else begin
            run_reg   <= run_next;
            cnt_reg   <= cnt_next;
            ratio_reg <= ratio_next;
            req_q_reg <= pad_biu_clkratio;
            done_reg  <= done_next;
        end
    end

    // Output decode; clk_en comes from registers only, clk_en_pre looks
    // one cycle ahead and is forced low while reset is asserted.
    always_comb begin
        clk_en         = run_reg && (cnt_reg == ratio_reg);
        clk_en_pre     = !clkrst && div_en && (cnt_next == ratio_next);
        cur_ratio      = ratio_reg;
        period_cnt     = cnt_reg;
        ratio_chg_done = done_reg;
    end

endmodule

// File: tb/tb_biu_clk_en_div.sv
// Directed bench for the bus clock-enable divider.
module tb_biu_clk_en_div;

    logic       i_pad_clk;
    logic       clkrst;
    logic       div_en;
    logic [2:0] pad_biu_clkratio;
    logic       clk_en;
    logic       clk_en_pre;
    logic [2:0] cur_ratio;
    logic [2:0] period_cnt;
    logic       ratio_chg_done;

    int n_vec;
    int n_err;

    biu_clk_en_div #(
        .RATIO_W     (3),
        .RESET_RATIO (3'd0)
    ) dut (
        .i_pad_clk        (i_pad_clk),
        .clkrst           (clkrst),
        .div_en           (div_en),
        .pad_biu_clkratio (pad_biu_clkratio),
        .clk_en           (clk_en),
        .clk_en_pre       (clk_en_pre),
        .cur_ratio        (cur_ratio),
        .period_cnt       (period_cnt),
        .ratio_chg_done   (ratio_chg_done)
    );

    initial i_pad_clk = 1'b0;
    always #5 i_pad_clk = ~i_pad_clk;

    // Advance past the next rising edge; inputs are driven right after
    task automatic tick();
        @(posedge i_pad_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        clkrst = 1'b1; div_en = 1'b1; pad_biu_clkratio = 3'd5;
        tick(); tick();
        settle();
        n_vec++;
        if ({clk_en, clk_en_pre, ratio_chg_done} !== 3'b000 || period_cnt !== 3'd0 || cur_ratio !== 3'd0) begin
            n_err++;
            $display("FAIL reset: en/pre/done=%b cnt=%0d ratio=%0d, want 000 cnt=0 ratio=0",
                     {clk_en, clk_en_pre, ratio_chg_done}, period_cnt, cur_ratio);
        end
        $display("reset: en=%b pre=%b done=%b cnt=%0d ratio=%0d", clk_en, clk_en_pre, ratio_chg_done, period_cnt, cur_ratio);
        pad_biu_clkratio = 3'd0; div_en = 1'b0; clkrst = 1'b0;
        tick();
    endtask

    task automatic test_ratio0();
        div_en = 1'b1;
        settle();
        n_vec++;
        if (clk_en_pre !== 1'b1) begin
            n_err++;
            $display("FAIL r0_pre_first: pre=%b want 1", clk_en_pre);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            settle();
            n_vec++;
            if (clk_en !== 1'b1 || clk_en_pre !== 1'b1 || ratio_chg_done !== 1'b0 || period_cnt !== 3'd0) begin
                n_err++;
                $display("FAIL r0_cycle%0d: en=%b pre=%b done=%b cnt=%0d want 1 1 0 0",
                         k, clk_en, clk_en_pre, ratio_chg_done, period_cnt);
            end
            $display("r0 cycle %0d: en=%b pre=%b cnt=%0d", k, clk_en, clk_en_pre, period_cnt);
        end
    endtask

    task automatic test_idle_ratio3();
        div_en = 1'b0;
        tick();
        pad_biu_clkratio = 3'd3;
        tick();
        settle();
        n_vec++;
        if (cur_ratio !== 3'd0 || ratio_chg_done !== 1'b0) begin
            n_err++;
            $display("FAIL r3_sample: ratio=%0d done=%b want 0 0", cur_ratio, ratio_chg_done);
        end
        tick();
        settle();
        n_vec++;
        if (cur_ratio !== 3'd3 || ratio_chg_done !== 1'b1 || clk_en !== 1'b0) begin
            n_err++;
            $display("FAIL r3_adopt: ratio=%0d done=%b en=%b want 3 1 0", cur_ratio, ratio_chg_done, clk_en);
        end
        $display("r3 adopt: ratio=%0d done=%b", cur_ratio, ratio_chg_done);
        div_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            settle();
            n_vec++;
            if (period_cnt !== 3'(k % 4) || clk_en !== (k % 4 == 3) ||
                clk_en_pre !== ((k + 1) % 4 == 3) || ratio_chg_done !== 1'b0) begin
                n_err++;
                $display("FAIL r3_run%0d: cnt=%0d en=%b pre=%b done=%b want cnt=%0d en=%b pre=%b done=0",
                         k, period_cnt, clk_en, clk_en_pre, ratio_chg_done,
                         k % 4, (k % 4 == 3), ((k + 1) % 4 == 3));
            end
            $display("r3 run %0d: cnt=%0d en=%b pre=%b", k, period_cnt, clk_en, clk_en_pre);
        end
    endtask

    // Entered with ratio 3 running and cnt=3
    task automatic test_ratio_down();
        int dones;
        dones = 0;
        tick(); tick();                       // cnt=1
        pad_biu_clkratio = 3'd1;
        tick();                               // cnt=2, req_q=1
        settle();
        n_vec++;
        if (cur_ratio !== 3'd3 || period_cnt !== 3'd2 || clk_en !== 1'b0 || clk_en_pre !== 1'b1) begin
            n_err++;
            $display("FAIL down_cnt2: ratio=%0d cnt=%0d en=%b pre=%b want 3 2 0 1",
                     cur_ratio, period_cnt, clk_en, clk_en_pre);
        end
        tick();                               // cnt=3, boundary
        settle();
        n_vec++;
        if (clk_en !== 1'b1 || cur_ratio !== 3'd3 || clk_en_pre !== 1'b0) begin
            n_err++;
            $display("FAIL down_boundary: en=%b ratio=%0d pre=%b want 1 3 0", clk_en, cur_ratio, clk_en_pre);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            settle();
            if (ratio_chg_done === 1'b1) dones++;
            n_vec++;
            if (cur_ratio !== 3'd1 || period_cnt !== 3'(k % 2) || clk_en !== (k % 2 == 1) ||
                clk_en_pre !== (k % 2 == 0)) begin
                n_err++;
                $display("FAIL down_run%0d: ratio=%0d cnt=%0d en=%b pre=%b want 1 %0d %b %b",
                         k, cur_ratio, period_cnt, clk_en, clk_en_pre, k % 2, (k % 2 == 1), (k % 2 == 0));
            end
            $display("down run %0d: ratio=%0d cnt=%0d en=%b done=%b", k, cur_ratio, period_cnt, clk_en, ratio_chg_done);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL down_done_count: got %0d pulses want 1", dones);
        end
    endtask

    task automatic test_multi_change();
        int dones;
        dones = 0;
        div_en = 1'b0; pad_biu_clkratio = 3'd7;
        tick(); tick();
        settle();
        n_vec++;
        if (cur_ratio !== 3'd7 || ratio_chg_done !== 1'b1) begin
            n_err++;
            $display("FAIL multi_r7: ratio=%0d done=%b want 7 1", cur_ratio, ratio_chg_done);
        end
        div_en = 1'b1;
        tick(); tick(); tick();               // cnt=2
        pad_biu_clkratio = 3'd2;
        tick();                               // cnt=3
        pad_biu_clkratio = 3'd5;
        tick();                               // cnt=4
        settle();
        if (ratio_chg_done === 1'b1) dones++;
        n_vec++;
        if (cur_ratio !== 3'd7 || period_cnt !== 3'd4) begin
            n_err++;
            $display("FAIL multi_hold: ratio=%0d cnt=%0d want 7 4", cur_ratio, period_cnt);
        end
        tick(); tick(); tick();               // cnt=7
        settle();
        if (ratio_chg_done === 1'b1) dones++;
        n_vec++;
        if (clk_en !== 1'b1 || cur_ratio !== 3'd7) begin
            n_err++;
            $display("FAIL multi_boundary: en=%b ratio=%0d want 1 7", clk_en, cur_ratio);
        end
        for (int j = 0; j < 12; j++) begin
            tick();
            settle();
            if (ratio_chg_done === 1'b1) dones++;
            n_vec++;
            if (cur_ratio !== 3'd5 || period_cnt !== 3'(j % 6) || clk_en !== (j % 6 == 5)) begin
                n_err++;
                $display("FAIL multi_run%0d: ratio=%0d cnt=%0d en=%b want 5 %0d %b",
                         j, cur_ratio, period_cnt, clk_en, j % 6, (j % 6 == 5));
            end
            $display("multi run %0d: ratio=%0d cnt=%0d en=%b done=%b", j, cur_ratio, period_cnt, clk_en, ratio_chg_done);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL multi_done_count: got %0d pulses want 1", dones);
        end
    endtask

    task automatic test_div_drop();
        div_en = 1'b0; pad_biu_clkratio = 3'd3;
        tick(); tick();                       // adopted while idle
        div_en = 1'b1;
        tick(); tick(); tick();               // cnt=2
        settle();
        n_vec++;
        if (period_cnt !== 3'd2 || cur_ratio !== 3'd3) begin
            n_err++;
            $display("FAIL drop_setup: cnt=%0d ratio=%0d want 2 3", period_cnt, cur_ratio);
        end
        div_en = 1'b0;
        tick();
        settle();
        n_vec++;
        if (clk_en !== 1'b0 || period_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL drop_next: en=%b cnt=%0d want 0 0", clk_en, period_cnt);
        end
        tick();
        div_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            settle();
            n_vec++;
            if (clk_en !== (k == 4) || period_cnt !== 3'(k - 1)) begin
                n_err++;
                $display("FAIL reenable%0d: en=%b cnt=%0d want %b %0d", k, clk_en, period_cnt, (k == 4), k - 1);
            end
            $display("reenable cycle %0d: en=%b cnt=%0d", k, clk_en, period_cnt);
        end
    endtask

    task automatic test_reset_mid();
        div_en = 1'b0; pad_biu_clkratio = 3'd4;
        tick(); tick();
        div_en = 1'b1;
        tick(); tick(); tick(); tick();       // cnt=3
        settle();
        n_vec++;
        if (period_cnt !== 3'd3 || cur_ratio !== 3'd4) begin
            n_err++;
            $display("FAIL rstmid_setup: cnt=%0d ratio=%0d want 3 4", period_cnt, cur_ratio);
        end
        clkrst = 1'b1;
        settle();
        n_vec++;
        if (clk_en_pre !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_pre: pre=%b want 0", clk_en_pre);
        end
        tick();
        settle();
        n_vec++;
        if ({clk_en, clk_en_pre, ratio_chg_done} !== 3'b000 || period_cnt !== 3'd0 || cur_ratio !== 3'd0) begin
            n_err++;
            $display("FAIL rstmid_after: en/pre/done=%b cnt=%0d ratio=%0d want 000 0 0",
                     {clk_en, clk_en_pre, ratio_chg_done}, period_cnt, cur_ratio);
        end
        $display("reset mid: en=%b pre=%b cnt=%0d ratio=%0d", clk_en, clk_en_pre, period_cnt, cur_ratio);
        pad_biu_clkratio = 3'd0;
        clkrst = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clkrst = 1'b1;
        div_en = 1'b0;
        pad_biu_clkratio = 3'd0;
        test_reset();
        test_ratio0();
        test_idle_ratio3();
        test_ratio_down();
        test_multi_change();
        test_div_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
